approx_mul_err_monitor: RTL and testbench

- Streaming error-characterisation stage that sits directly downstream of the 8x8 approximate Dadda multipliers.
- Per sample it consumes the operand pair and the approximate product, computes the exact product internally, and takes the error distance ED = |exact - approx|.
- Over a programmable window it accumulates error count, ED sum and maximum ED (with the operands that produced it), then presents one result record through a valid/ready handshake.

---
 rtl/approx_mul_err_monitor.sv | 179 +++++++++++++++++
 tb/tb_approx_mul_err_monitor.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mul_err_monitor.sv
// approx_mul_err_monitor
//   Error-characterisation stage for an 8x8 approximate multiplier. Each
//   accepted sample (a, b, approx) is registered once (S1). The exact product
//   and the error distance ED = |a*b - approx| are formed from the S1
//   registers, and S2 folds ED into the window statistics. After win_len
//   samples, one result record is offered on a valid/ready handshake.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start, win_len    window start pulse (taken only in IDLE) and length
//   in_valid/in_ready sample handshake; in_a, in_b, in_approx sample payload
//   res_valid/ready   result handshake
//   res_err_cnt       samples with ED != 0
//   res_sum_ed        saturating ED sum; res_ovf is set if it ever clamped
//   res_max_ed        largest ED; res_max_a/b are operands of its first occurrence
//   busy              high whenever the FSM is not in IDLE
module approx_mul_err_monitor #(
    parameter int WIDTH  = 8,
    parameter int PWIDTH = 16,
    parameter int CNT_W  = 17,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  win_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    input  logic [PWIDTH-1:0] in_approx,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CNT_W-1:0]  res_err_cnt,
    output logic [ACC_W-1:0]  res_sum_ed,
    output logic [PWIDTH-1:0] res_max_ed,
    output logic [WIDTH-1:0]  res_max_a,
    output logic [WIDTH-1:0]  res_max_b,
    output logic              res_ovf,
    output logic              busy
);

    // One spare bit above the wider of sum and ED, so the carry out of the
    // addition can be seen and clamped.
    localparam int SW = ((ACC_W > PWIDTH) ? ACC_W : PWIDTH) + 1;
    localparam logic [SW-1:0] SUM_MAX = SW'({ACC_W{1'b1}});

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]  win_len_q;
    logic [CNT_W-1:0]  accepted;
    logic [CNT_W-1:0]  accepted_inc;
    logic              accept;
    logic              last_accept;
    logic              start_go;

    logic              s1_vld;
    logic [WIDTH-1:0]  s1_a;
    logic [WIDTH-1:0]  s1_b;
    logic [PWIDTH-1:0] s1_approx;
    logic [PWIDTH-1:0] exact;
    logic [PWIDTH-1:0] ed;
    logic [SW-1:0]     sum_wide;
    logic              sum_sat;

    logic [CNT_W-1:0]  err_cnt;
    logic [ACC_W-1:0]  sum_ed;
    logic [PWIDTH-1:0] max_ed;
    logic [WIDTH-1:0]  max_a;
    logic [WIDTH-1:0]  max_b;
    logic              ovf;

    assign accept       = in_valid & in_ready;
    assign accepted_inc = accepted + 1'b1;
    assign last_accept  = accept && (accepted_inc == win_len_q);
    assign start_go     = (state == IDLE) && start;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = (win_len == '0) ? DONE : RUN;
            RUN:   if (last_accept) state_nxt = DRAIN;
            // The last sample is still in S1 on the first DRAIN cycle. Wait
            // until it has been folded into the accumulators.
            DRAIN: if (!s1_vld) state_nxt = DONE;
            DONE:  if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs (registered state only) ----------------
    always_comb begin
        in_ready  = (state == RUN) && (accepted < win_len_q);
        res_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // ---------------- window length / accept counter ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_len_q <= '0;
            accepted  <= '0;
        end else if (start_go) begin
            win_len_q <= win_len;
            accepted  <= '0;
        end else if (accept) begin
            accepted  <= accepted_inc;
        end
    end

    // ---------------- S1: sample register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld    <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_approx <= '0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_a      <= in_a;
                s1_b      <= in_b;
                s1_approx <= in_approx;
            end
        end
    end

    assign exact    = {{(PWIDTH-WIDTH){1'b0}}, s1_a} * {{(PWIDTH-WIDTH){1'b0}}, s1_b};
    assign ed       = (exact >= s1_approx) ? (exact - s1_approx) : (s1_approx - exact);
    assign sum_wide = SW'(sum_ed) + SW'(ed);
    assign sum_sat  = (sum_wide > SUM_MAX);

    // ---------------- S2: window accumulators ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
            sum_ed  <= '0;
            max_ed  <= '0;
            max_a   <= '0;
            max_b   <= '0;
            ovf     <= 1'b0;
        end else if (start_go) begin
            err_cnt <= '0;
            sum_ed  <= '0;
            max_ed  <= '0;
            max_a   <= '0;
            max_b   <= '0;
            ovf     <= 1'b0;
        end else if (s1_vld) begin
            if (ed != '0) err_cnt <= err_cnt + 1'b1;
            sum_ed <= sum_sat ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
            if (sum_sat) ovf <= 1'b1;
            // A strict compare keeps the first sample on a tie. It also keeps
            // max_a and max_b at zero while every ED is zero.
            if (ed > max_ed) begin
                max_ed <= ed;
                max_a  <= s1_a;
                max_b  <= s1_b;
            end
        end
    end

    assign res_err_cnt = err_cnt;
    assign res_sum_ed  = sum_ed;
    assign res_max_ed  = max_ed;
    assign res_max_a   = max_a;
    assign res_max_b   = max_b;
    assign res_ovf     = ovf;

endmodule

// File: tb/tb_approx_mul_err_monitor.sv
`timescale 1ns/1ps
module tb_approx_mul_err_monitor;
    localparam int WIDTH = 8, PWIDTH = 16, CNT_W = 17, ACC_W = 32;

    logic clk = 1'b0;
    logic rst;
    logic start, in_valid, res_ready;
    logic [CNT_W-1:0]  win_len;
    logic [WIDTH-1:0]  in_a, in_b;
    logic [PWIDTH-1:0] in_approx;

    logic in_ready, res_valid, res_ovf, busy;
    logic [CNT_W-1:0]  res_err_cnt;
    logic [ACC_W-1:0]  res_sum_ed;
    logic [PWIDTH-1:0] res_max_ed;
    logic [WIDTH-1:0]  res_max_a, res_max_b;

    logic s_in_ready, s_res_valid, s_ovf, s_busy;
    logic [CNT_W-1:0]  s_err_cnt;
    logic [15:0]       s_sum_ed;
    logic [PWIDTH-1:0] s_max_ed;
    logic [WIDTH-1:0]  s_max_a, s_max_b;

    always #5 clk = ~clk;

    approx_mul_err_monitor #(.WIDTH(WIDTH), .PWIDTH(PWIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .win_len(win_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_approx(in_approx),
        .res_valid(res_valid), .res_ready(res_ready), .res_err_cnt(res_err_cnt),
        .res_sum_ed(res_sum_ed), .res_max_ed(res_max_ed), .res_max_a(res_max_a),
        .res_max_b(res_max_b), .res_ovf(res_ovf), .busy(busy));

    // Same stimulus, with a 16-bit accumulator, so that saturation can be reached.
    approx_mul_err_monitor #(.WIDTH(WIDTH), .PWIDTH(PWIDTH), .CNT_W(CNT_W), .ACC_W(16)) dut16 (
        .clk(clk), .rst(rst), .start(start), .win_len(win_len),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_a(in_a), .in_b(in_b), .in_approx(in_approx),
        .res_valid(s_res_valid), .res_ready(res_ready), .res_err_cnt(s_err_cnt),
        .res_sum_ed(s_sum_ed), .res_max_ed(s_max_ed), .res_max_a(s_max_a),
        .res_max_b(s_max_b), .res_ovf(s_ovf), .busy(s_busy));

    typedef struct { longint a; longint b; longint ap; } smp_t;
    smp_t wq[$];

    int n_cmp = 0, n_bad = 0;
    longint m_cnt, m_sum, m_max, m_a, m_b;
    bit     m_ovf;

    // Reference model: window statistics from the list of accepted samples.
    task automatic model(input int acc_w);
        longint tot, ex, ed, lim;
        tot = 0; m_cnt = 0; m_max = 0; m_a = 0; m_b = 0;
        foreach (wq[i]) begin
            ex = wq[i].a * wq[i].b;
            ed = (ex > wq[i].ap) ? ex - wq[i].ap : wq[i].ap - ex;
            if (ed != 0) m_cnt++;
            tot += ed;
            if (ed > m_max) begin m_max = ed; m_a = wq[i].a; m_b = wq[i].b; end
        end
        lim   = (longint'(1) << acc_w) - 1;
        m_sum = (tot > lim) ? lim : tot;
        m_ovf = (tot > lim);
    endtask

    function automatic logic [81:0] got32();
        return {res_err_cnt, res_sum_ed, res_max_ed, res_max_a, res_max_b, res_ovf};
    endfunction
    function automatic logic [81:0] exp32();
        return {m_cnt[CNT_W-1:0], m_sum[31:0], m_max[15:0], m_a[7:0], m_b[7:0], m_ovf};
    endfunction
    function automatic logic [65:0] got16();
        return {s_err_cnt, s_sum_ed, s_max_ed, s_max_a, s_max_b, s_ovf};
    endfunction
    function automatic logic [65:0] exp16();
        return {m_cnt[CNT_W-1:0], m_sum[15:0], m_max[15:0], m_a[7:0], m_b[7:0], m_ovf};
    endfunction

    task automatic do_start(input int len);
        start = 1'b1; win_len = CNT_W'(len);
        @(posedge clk); #1;
        start = 1'b0;
        wq.delete();
    endtask

    // Offer one sample until it is accepted. On return we are 1ns past the accepting edge.
    task automatic send(input int a, input int b, input int ap, output bit ok);
        smp_t s;
        in_valid = 1'b1; in_a = WIDTH'(a); in_b = WIDTH'(b); in_approx = PWIDTH'(ap);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (ok) begin s.a = a; s.b = b; s.ap = ap; wq.push_back(s); end
    endtask

    task automatic wait_res(output int cyc);
        cyc = 0;
        while (!res_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
    endtask

    task automatic take_res();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, res_valid, busy, got32()} !== '0) begin
            n_bad++; $display("FAIL reset_state got %h required 0", {in_ready, res_valid, busy, got32()});
        end
        n_cmp++;
        if ({s_in_ready, s_res_valid, s_busy, got16()} !== '0) begin
            n_bad++; $display("FAIL reset_state16 got %h required 0", {s_in_ready, s_res_valid, s_busy, got16()});
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_exact();
        bit ok, all_ok; int cyc;
        all_ok = 1'b1;
        do_start(3);
        send(3, 5, 15, ok);        all_ok &= ok;
        send(7, 7, 49, ok);        all_ok &= ok;
        send(255, 255, 65025, ok); all_ok &= ok;
        wait_res(cyc);
        n_cmp++;
        if (!all_ok || !res_valid) begin n_bad++; $display("FAIL exact_handshake ok %0d res_valid %0d required 1 1", all_ok, res_valid); end
        model(32);
        n_cmp++;
        if (got32() !== exp32()) begin n_bad++; $display("FAIL exact_window got %h required %h", got32(), exp32()); end
        n_cmp++;
        if (got32() !== '0) begin n_bad++; $display("FAIL exact_all_zero got %h required 0", got32()); end
        take_res();
    endtask

    task automatic test_error();
        bit ok, all_ok; int cyc;
        all_ok = 1'b1;
        do_start(2);
        send(10, 10, 90, ok); all_ok &= ok;
        send(2, 3, 8, ok);    all_ok &= ok;
        wait_res(cyc);
        n_cmp++;
        if (!all_ok || cyc != 2) begin n_bad++; $display("FAIL error_latency got %0d edges (ok %0d) required 2", cyc, all_ok); end
        model(32);
        n_cmp++;
        if (got32() !== exp32()) begin n_bad++; $display("FAIL error_window got %h required %h", got32(), exp32()); end
        n_cmp++;
        if (res_sum_ed !== 32'd12 || res_max_ed !== 16'd10) begin
            n_bad++; $display("FAIL error_sum_max got %0d/%0d required 12/10", res_sum_ed, res_max_ed);
        end
        take_res();
    endtask

    task automatic test_tie();
        bit ok, all_ok; int cyc;
        all_ok = 1'b1;
        do_start(2);
        send(4, 4, 14, ok); all_ok &= ok;
        send(1, 3, 1, ok);  all_ok &= ok;
        wait_res(cyc);
        model(32);
        n_cmp++;
        if (!all_ok || got32() !== exp32()) begin n_bad++; $display("FAIL tie_window got %h required %h ok %0d", got32(), exp32(), all_ok); end
        n_cmp++;
        if (res_max_a !== 8'd4 || res_max_b !== 8'd4) begin
            n_bad++; $display("FAIL tie_first got a=%0d b=%0d required a=4 b=4", res_max_a, res_max_b);
        end
        take_res();
    endtask

    task automatic test_handshake();
        bit ok, all_ok, changed; int cyc;
        logic [81:0] held;
        all_ok = 1'b1; changed = 1'b0;
        do_start(4);
        for (int i = 0; i < 4; i++) begin
            send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 65535)), ok);
            all_ok &= ok;
            if (i < 3) begin @(posedge clk); #1; end
        end
        n_cmp++;
        if (!all_ok || in_ready !== 1'b0) begin n_bad++; $display("FAIL hs_in_ready_drop got %0d required 0 (ok %0d)", in_ready, all_ok); end
        // Keep offering a sample that must not be consumed.
        in_valid = 1'b1; in_a = 8'd200; in_b = 8'd200; in_approx = 16'd0;
        wait_res(cyc);
        model(32);
        held = got32();
        n_cmp++;
        if (!res_valid || held !== exp32()) begin n_bad++; $display("FAIL hs_window got %h required %h", held, exp32()); end
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin start = 1'b1; win_len = 17'd7; end
            @(posedge clk); #1;
            start = 1'b0;
            if (res_valid !== 1'b1 || got32() !== held) changed = 1'b1;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (changed) begin n_bad++; $display("FAIL hs_stable got %h required %h", got32(), held); end
        take_res();
        n_cmp++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL hs_idle got valid %0d busy %0d required 0 0", res_valid, busy); end
        n_cmp++;
        if (got32() !== held) begin n_bad++; $display("FAIL hs_keep got %h required %h", got32(), held); end
    endtask

    task automatic test_empty();
        do_start(0);
        n_cmp++;
        if (res_valid !== 1'b1 || got32() !== '0) begin
            n_bad++; $display("FAIL empty_window got valid %0d res %h required 1 0", res_valid, got32());
        end
        take_res();
    endtask

    task automatic test_saturation();
        bit ok, all_ok; int cyc;
        all_ok = 1'b1;
        do_start(2);
        send(255, 255, 0, ok); all_ok &= ok;
        send(255, 255, 0, ok); all_ok &= ok;
        wait_res(cyc);
        model(16);
        n_cmp++;
        if (!all_ok || !s_res_valid || got16() !== exp16()) begin
            n_bad++; $display("FAIL sat16 got %h required %h", got16(), exp16());
        end
        n_cmp++;
        if (s_sum_ed !== 16'hFFFF || s_ovf !== 1'b1) begin n_bad++; $display("FAIL sat16_clamp got %h/%0d required ffff/1", s_sum_ed, s_ovf); end
        model(32);
        n_cmp++;
        if (got32() !== exp32()) begin n_bad++; $display("FAIL sat32_nosat got %h required %h", got32(), exp32()); end
        take_res();
    endtask

    task automatic test_reset_mid();
        bit ok, all_ok; int cyc;
        all_ok = 1'b1;
        do_start(3);
        send(3, 3, 1, ok); all_ok &= ok;
        @(posedge clk); #1;
        rst = 1'b1; #1;
        n_cmp++;
        if ({in_ready, res_valid, busy, got32()} !== '0) begin
            n_bad++; $display("FAIL reset_mid got %h required 0", {in_ready, res_valid, busy, got32()});
        end
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        do_start(1);
        send(2, 2, 5, ok); all_ok &= ok;
        wait_res(cyc);
        model(32);
        n_cmp++;
        if (!all_ok || !res_valid || got32() !== exp32()) begin
            n_bad++; $display("FAIL after_reset got %h required %h ok %0d", got32(), exp32(), all_ok);
        end
        take_res();
    endtask

    task automatic test_random();
        bit ok, all_ok; int cyc, len, a, b, ex, ap;
        for (int w = 0; w < 12; w++) begin
            all_ok = 1'b1;
            len = int'($urandom_range(1, 8));
            do_start(len);
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                a = int'($urandom_range(0, 255));
                b = int'($urandom_range(0, 255));
                ex = a * b;
                case ($urandom_range(0, 3))
                    0: ap = ex;
                    1: ap = ex + int'($urandom_range(0, 300));
                    2: ap = ex - int'($urandom_range(0, 300));
                    default: ap = int'($urandom_range(0, 65535));
                endcase
                if (ap < 0) ap = 0;
                if (ap > 65535) ap = 65535;
                send(a, b, ap, ok); all_ok &= ok;
            end
            wait_res(cyc);
            model(32);
            n_cmp++;
            if (!all_ok || !res_valid || got32() !== exp32()) begin
                n_bad++; $display("FAIL random_win%0d got %h required %h", w, got32(), exp32());
            end
            model(16);
            n_cmp++;
            if (got16() !== exp16()) begin n_bad++; $display("FAIL random16_win%0d got %h required %h", w, got16(), exp16()); end
            take_res();
        end
    endtask

    initial begin
        start = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        win_len = '0; in_a = '0; in_b = '0; in_approx = '0;
        test_reset();
        test_exact();
        test_error();
        test_tie();
        test_handshake();
        test_empty();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
